// File: rtl/writeback_regfile_pkg.sv
// Shared constants and types for the register file, so decode, the hazard
// unit and writeback agree on index/data widths and the zero register.
package writeback_regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int REG_ZERO  = 0;
    localparam int NUM_REGS  = 2 ** RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;
    typedef logic [RF_DATA_W-1:0] data_word_t;

    // Depth of a register file with the given index width.
    function automatic int num_regs(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/writeback_regfile_bypass_sel.sv
// Per-port read selector: returns zero for r0 or during reset, the in-flight
// write-back data when it targets this port's index (if bypass is enabled),
// otherwise the stored register value.
module regfile_bypass_sel #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] rd_data
);

    // Priority: reset, then zero register, then forwarding, then storage.
    // A nonzero rd_addr matching wb_addr implies the write is to a real entry.
    always_comb begin
        rd_data = stored;
        if (rst || (rd_addr == '0)) begin
            rd_data = '0;
        end else if ((BYPASS != 0) && wb_en && (wb_addr == rd_addr)) begin
            rd_data = wb_data;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// 32-entry MIPS-style register file with two combinational read ports
// (optional write-to-read bypass), a registered debug read port, and a
// saturating count of committed writes.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = num_regs(ADDR_W);

    logic [DATA_W-1:0] w_stored [DEPTH];
    logic              w_commit;
    logic [DATA_W-1:0] r_dbg_data;
    logic [CNT_W-1:0]  r_wr_count;

    // A write commits only outside reset and never to the zero register.
    assign w_commit = !rst && wb_en && (wb_addr != ADDR_W'(REG_ZERO));

    // Entry 0 has no storage; it is a constant zero.
    assign w_stored[0] = '0;

    // Entries are flops rather than RAM so that reset clears every one.
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] r_entry;

            // Clear on reset, load on a committed write addressed here.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_entry <= '0;
                end else if (w_commit && (wb_addr == ADDR_W'(gi))) begin
                    r_entry <= wb_data;
                end
            end

            assign w_stored[gi] = r_entry;
        end
    endgenerate

    // Debug read samples the pre-write stored value; no forwarding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= w_stored[dbg_addr];
        end
    end

    // Count committed writes, holding at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (w_commit && (r_wr_count != '1)) begin
            r_wr_count <= r_wr_count + CNT_W'(1);
        end
    end

    assign dbg_data = r_dbg_data;
    assign wr_count = r_wr_count;

    regfile_bypass_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_sel_rs (
        .rst     (rst),
        .rd_addr (rs_addr),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .stored  (w_stored[rs_addr]),
        .rd_data (rs_data)
    );

    regfile_bypass_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_sel_rt (
        .rst     (rst),
        .rd_addr (rt_addr),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .stored  (w_stored[rt_addr]),
        .rd_data (rt_data)
    );

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: two instances share stimulus, one default
// (bypass on, 32-bit counter) and one with bypass off and a 4-bit counter.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  dbg_addr = '0;

    logic [31:0] a_rs, a_rt, a_dbg, a_cnt;
    logic [31:0] b_rs, b_rt, b_dbg;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state: register contents and per-instance counters.
    logic [31:0] m_mem [32];
    longint      m_cnt_a = 0;
    int          m_cnt_b = 0;
    logic [31:0] m_dbg = '0;

    always #5 clk = ~clk;

    writeback_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(a_rs), .rt_data(a_rt), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(a_dbg), .wr_count(a_cnt)
    );

    writeback_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(b_rs), .rt_data(b_rt), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(b_dbg), .wr_count(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected read-port value straight from the architectural rules.
    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit bypass);
        if (rst || a == 0) return 32'h0;
        if (bypass && wb_en && wb_addr != 0 && wb_addr == a) return wb_data;
        return m_mem[a];
    endfunction

    // One clock: drive, check combinational reads, clock, update model, check
    // registered outputs. Prints one line per transaction.
    task automatic step(input bit r, input bit en, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [4:0] da);
        bit commit;
        @(negedge clk);
        rst = r; wb_en = en; wb_addr = wa; wb_data = wd;
        rs_addr = ra; rt_addr = rb; dbg_addr = da;
        #1;
        check("a_rs", a_rs, exp_read(ra, 1'b1));
        check("a_rt", a_rt, exp_read(rb, 1'b1));
        check("b_rs", b_rs, exp_read(ra, 1'b0));
        check("b_rt", b_rt, exp_read(rb, 1'b0));
        @(posedge clk);
        commit = !r && en && (wa != 0);
        m_dbg = r ? 32'h0 : m_mem[da];
        if (r) begin
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (commit) begin
            m_mem[wa] = wd;
            if (m_cnt_a < 64'hFFFF_FFFF) m_cnt_a++;
            if (m_cnt_b < 15) m_cnt_b++;
        end
        #1;
        check("a_dbg", a_dbg, m_dbg);
        check("b_dbg", b_dbg, m_dbg);
        check("a_cnt", a_cnt, 32'(m_cnt_a));
        check("b_cnt", {28'h0, b_cnt}, 32'(m_cnt_b));
        $display("txn rst=%0d en=%0d wa=%0d wd=%08h rs=%0d rt=%0d dbg=%0d | a_rs=%08h a_rt=%08h b_rs=%08h a_dbg=%08h a_cnt=%0d b_cnt=%0d",
                 r, en, wa, wd, ra, rb, da, a_rs, a_rt, b_rs, a_dbg, a_cnt, b_cnt);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = '0;

        // Reset held two cycles with a write presented: discarded.
        step(1, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
        step(1, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
        step(0, 0, 5'd0, 32'h0,         5'd5, 5'd5, 5'd5);
        check("rst_r5",  a_rs, 32'h0);
        check("rst_cnt", a_cnt, 32'h0);

        // Basic write then read.
        step(0, 1, 5'd8, 32'h1234_5678, 5'd1, 5'd2, 5'd0);
        step(0, 0, 5'd0, 32'h0,         5'd8, 5'd8, 5'd8);
        check("r8_read", a_rs, 32'h1234_5678);
        check("r8_cnt",  a_cnt, 32'd1);

        // Same-cycle bypass on both ports; instance b sees the old value.
        step(0, 1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9);

        // Zero register write is ignored and reads zero.
        step(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        step(0, 0, 5'd0, 32'h0,         5'd0, 5'd0, 5'd0);
        check("r0_cnt", a_cnt, 32'd2);

        // Debug port returns pre-write value, then the new one.
        step(0, 1, 5'd3, 32'h11, 5'd0, 5'd0, 5'd0);
        step(0, 1, 5'd3, 32'h22, 5'd0, 5'd0, 5'd3);
        check("dbg_pre", a_dbg, 32'h11);
        step(0, 0, 5'd0, 32'h0,  5'd0, 5'd0, 5'd3);
        check("dbg_post", a_dbg, 32'h22);

        // Drive the 4-bit counter into saturation.
        for (int i = 0; i < 16; i++)
            step(0, 1, 5'(1 + (i % 31)), $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
        check("sat_b", {28'h0, b_cnt}, 32'hF);

        // Reset beats a concurrent write to r7.
        step(1, 1, 5'd7, 32'h7777_7777, 5'd7, 5'd7, 5'd7);
        step(0, 0, 5'd0, 32'h0,         5'd7, 5'd7, 5'd7);
        check("rst_r7",  a_rs, 32'h0);
        check("rst_cnt2", a_cnt, 32'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            bit r;
            logic [4:0] wa;
            r  = ($urandom_range(0, 31) == 0);
            wa = 5'($urandom);
            step(r, $urandom_range(0, 3) != 0, wa, $urandom,
                 ($urandom_range(0, 2) == 0) ? wa : 5'($urandom),
                 ($urandom_range(0, 2) == 0) ? wa : 5'($urandom),
                 5'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
MIPS-style 32-entry general-purpose register file. Consumes the write-back result selected by the writeback stage's 2:1 select (ALU result vs. load data) and the destination register from the MEM/WB latch. Serves two combinational read ports to the decode stage, with write-to-read bypass so decode sees a same-cycle write-back. Also provides a debug read port and a saturating retired-write counter for bring-up.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored value only
CNT_W, 32, width of the write counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
rs_addr  input  ADDR_W  read port A index (decode rs)
rt_addr  input  ADDR_W  read port B index (decode rt)
rs_data  output  DATA_W  read port A data, combinational
rt_data  output  DATA_W  read port B data, combinational
wb_en  input  1  write enable (MEM/WB RegWrite)
wb_addr  input  ADDR_W  write index (MEM/WB destination register)
wb_data  input  DATA_W  write data (writeback mux output)
dbg_addr  input  ADDR_W  debug read index
dbg_data  output  DATA_W  debug read data, registered, 1-cycle latency
wr_count  output  CNT_W  count of committed writes to nonzero registers, saturating

Behaviour:
- Storage: 2**ADDR_W entries of DATA_W bits. Entry 0 is hardwired to zero: never written, always reads 0.
- Reset: when rst is high at a rising clk edge, all entries go to 0, dbg_data goes to 0, and wr_count goes to 0. Writes presented in that cycle are discarded and not counted.
- Reset mid-operation: reset wins over any concurrent write. The first write accepted is the one presented on the first edge with rst low.
- While rst is high, rs_data, rt_data and the bypass path are forced to 0.
- Write: on a rising edge with rst=0, wb_en=1 and wb_addr!=0, entry[wb_addr] <= wb_data. A write with wb_addr=0 is a no-op and is not counted.
- Reads are combinational from rs_addr and rt_addr.
  - If BYPASS=1, wb_en=1, wb_addr!=0 and wb_addr equals the read index, the port returns wb_data (write-before-read semantics).
  - Otherwise the port returns the stored entry.
  - Index 0 always returns 0, including when wb_addr=0 is written with nonzero data.
- Both read ports may address the same entry, and may match the write index simultaneously; both then return wb_data.
- Debug port: on each edge, dbg_data <= stored value at dbg_addr. This is the pre-write value when the same entry is written on the same edge. The debug port never bypasses.
- wr_count increments by 1 on each committed write and saturates at all-ones.
- No X propagation: every entry has a defined reset value.

Decomposition:
- Shared package/include: constant REG_ZERO = 0, constant NUM_REGS = 2**ADDR_W, and the register index and data word widths, so decode, the hazard unit and writeback agree.
- One natural sub-module, regfile_bypass_sel: a combinational per-port selector (read index, write en/addr/data, stored value -> port data), instantiated twice.
- The storage array and wr_count stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with wb_en=1, wb_addr=5, wb_data=0xDEADBEEF -> rs_data(addr 5)=0 after reset, wr_count=0, dbg_data=0.
- Basic write/read: write 0x12345678 to r8. Next cycle, with wb_en=0 and rs_addr=8 -> rs_data=0x12345678, wr_count=1.
- Bypass: wb_en=1, wb_addr=9, wb_data=0xA5A5A5A5, rs_addr=rt_addr=9 in the same cycle -> both ports=0xA5A5A5A5 before the edge.
  - With BYPASS=0: both ports return the old value (0).
- Zero register: write 0xFFFFFFFF to r0, then read rs_addr=0 in the same cycle and the next -> 0 both times, wr_count unchanged.
- Debug port: r3=0x11, then write r3=0x22 with dbg_addr=3 -> dbg_data=0x11 after that edge, 0x22 one edge later.
- Saturation and reset priority:
  - Force wr_count to all-ones (CNT_W=4 build), commit a write -> wr_count stays 0xF.
  - Assert rst together with a write to r7 -> r7=0, wr_count=0.
